// File: rtl/dual_buf_y_arbiter.sv
// dual_buf_y_arbiter: Y-side scheduler for the dual asynchronous byte buffer.
// Round-robins the single Y port between channel A (0) and channel B (1).
// Within a grant, host writes take priority over reads. The grant ends when
// neither direction has work, or after BURST_MAX transfers.
// Optional build macro: DUAL_BUF_ARB_WR_THRESH_EN. When it is defined, the first
// write of a grant waits until the target FIFO reports at least WR_THRESH free
// bytes.
module dual_buf_y_arbiter #(
    parameter int BURST_MAX = 16,
    parameter int SETTLE    = 2,
    parameter int WR_THRESH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] in_dat_i,
    input  logic       in_ch_i,
    input  logic       in_valid_i,
    output logic       in_ack_o,
    output logic [7:0] out_dat_o,
    output logic       out_ch_o,
    output logic       out_valid_o,
    input  logic       out_ack_i,
    output logic       Y_sel_o,
    output logic       Y_rd_o,
    output logic       Y_wr_o,
    output logic [7:0] Y_dat_o,
    input  logic [7:0] Y_dat_i,
    input  logic       Y_empty_i,
    input  logic       Y_full_i,
    input  logic [7:0] Y_count_i
);

    typedef enum logic [2:0] {SEL, EVAL, RD, RCAP, RHOLD, WR, WGAP} state_e;

    localparam logic [7:0] BURST_LIM     = 8'(BURST_MAX);
    localparam logic [2:0] SETTLE_LIM    = 3'(SETTLE);
    localparam logic [7:0] WR_THRESH_LIM = 8'(WR_THRESH);

    state_e     state_q, state_d;
    logic       ch_q, ch_d;
    logic [2:0] settle_cnt_q, settle_cnt_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] out_dat_q, out_dat_d;
    logic       out_ch_q, out_ch_d;
    logic       out_valid_q, out_valid_d;
    logic       burst_done;
    logic       thresh_ok;
    logic       wr_go;

`ifdef DUAL_BUF_ARB_WR_THRESH_EN
    // Only the opening write of a grant waits for enough free space.
    assign thresh_ok = (burst_cnt_q != 8'd0) || (Y_count_i >= WR_THRESH_LIM);
`else
    logic unused_count;
    assign thresh_ok    = 1'b1;
    assign unused_count = ^{Y_count_i, WR_THRESH_LIM};
`endif

    assign burst_done = (burst_cnt_q >= BURST_LIM);
    assign wr_go      = in_valid_i && (in_ch_i == ch_q) && !Y_full_i && thresh_ok;

    // The channel select is the registered channel, so it only moves when SEL is entered.
    assign Y_sel_o     = ch_q;
    assign out_dat_o   = out_dat_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;

    // State register and held read byte. Reset drops any byte not yet accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= SEL;
            ch_q         <= 1'b0;
            settle_cnt_q <= 3'd0;
            burst_cnt_q  <= 8'd0;
            out_dat_q    <= 8'd0;
            out_ch_q     <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here updates from pre-edge values.
            state_q      <= state_d;
            ch_q         <= ch_d;
            settle_cnt_q <= settle_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            out_dat_q    <= out_dat_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Next-state logic plus the single-cycle buffer and host strobes.
    always_comb begin
        // NOTE: give every output a default first. A path that leaves one unassigned would infer a latch.
        state_d      = state_q;
        ch_d         = ch_q;
        settle_cnt_d = settle_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        out_dat_d    = out_dat_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = out_valid_q;
        Y_rd_o       = 1'b0;
        Y_wr_o       = 1'b0;
        Y_dat_o      = 8'd0;
        in_ack_o     = 1'b0;

        case (state_q)
            SEL: begin
                if (settle_cnt_q == SETTLE_LIM) begin
                    settle_cnt_d = 3'd0;
                    state_d      = EVAL;
                end else begin
                    settle_cnt_d = settle_cnt_q + 3'd1;
                end
            end
            EVAL: begin
                if (wr_go) begin
                    state_d = WR;
                end else if (!Y_empty_i) begin
                    state_d = RD;
                end else begin
                    ch_d        = ~ch_q;
                    burst_cnt_d = 8'd0;
                    state_d     = SEL;
                end
            end
            RD: begin
                Y_rd_o      = 1'b1;
                burst_cnt_d = burst_cnt_q + 8'd1;
                state_d     = RCAP;
            end
            RCAP: begin
                // The buffer RAM presents the byte one cycle after the strobe.
                out_dat_d   = Y_dat_i;
                out_ch_d    = ch_q;
                out_valid_d = 1'b1;
                state_d     = RHOLD;
            end
            RHOLD: begin
                if (out_ack_i) begin
                    out_valid_d = 1'b0;
                    if (burst_done) begin
                        ch_d        = ~ch_q;
                        burst_cnt_d = 8'd0;
                        state_d     = SEL;
                    end else begin
                        state_d = EVAL;
                    end
                end
            end
            WR: begin
                Y_wr_o      = 1'b1;
                Y_dat_o     = in_dat_i;
                in_ack_o    = 1'b1;
                burst_cnt_d = burst_cnt_q + 8'd1;
                state_d     = WGAP;
            end
            WGAP: begin
                // Idle cycle that lets the full flag catch up with the write.
                if (burst_done) begin
                    ch_d        = ~ch_q;
                    burst_cnt_d = 8'd0;
                    state_d     = SEL;
                end else begin
                    state_d = EVAL;
                end
            end
            default: begin
                state_d = SEL;
            end
        endcase
    end

endmodule
